mdu_controller: RTL and testbench
=================================

MDU_CONTROLLER -- requirements
Module: mdu_controller

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1, EX-stage request: R-type op 0110011 with funct7 0000001.
REQ-004 SHALL have port funct3, input, 3, operation select; sampled with start.
REQ-005 SHALL have ports src_a, input, 32 and src_b, input, 32, operands; sampled with start.
REQ-006 SHALL have port flush, input, 1, kills the in-flight operation.
REQ-007 SHALL have port stall, output, 1, freezes IF/ID/EX while the operation runs.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking result valid.
REQ-009 SHALL have port result, output, 32, operation result.
REQ-010 SHALL have port busy, output, 1, high in states MUL and DIV.
REQ-011 SHALL have port illegal, output, 1, unsupported-funct3 indication.

Function
REQ-012 SHALL support funct3 000 MUL (low 32 bits), 011 MULHU (high 32 bits, unsigned), 101 DIVU and 111 REMU; all other funct3 values are unsupported.
REQ-013 SHALL implement FSM states IDLE, MUL, DIV and DONE.
REQ-014 IDLE: start with MUL/MULHU -> MUL; start with DIVU/REMU -> DIV; operands and funct3 latched on the same edge.
REQ-015 MUL: iterative shift-add over a 64-bit product, one bit per cycle, 32 cycles (5-bit counter 0..31), then -> DONE.
REQ-016 DIV: restoring division, one quotient bit per cycle, 32 cycles, then -> DONE.
REQ-017 DONE: done=1 and result valid for exactly one cycle, then -> IDLE unconditionally.
REQ-018 Latency: start sampled at edge N -> done high in the cycle after edge N+33.
REQ-019 stall = (IDLE and start and supported funct3 and not flush) or MUL or DIV; stall is low in DONE so the pipeline captures result.
REQ-020 Divide by zero SHALL give DIVU = 0xFFFFFFFF and REMU = src_a, with normal 32-cycle latency.
REQ-021 result SHALL be registered, loaded only on entry to DONE, and held until the next DONE.
REQ-022 flush in MUL or DIV SHALL force IDLE on the next edge: no done, result unchanged.
REQ-023 flush in DONE has no effect; flush with start in IDLE -> start ignored, stall low.
REQ-024 start while busy or in DONE SHALL be ignored.
REQ-025 illegal SHALL be combinational: high when state IDLE, start=1, flush=0 and funct3 is unsupported; FSM stays in IDLE and stall is low.

Reset
REQ-026 rst SHALL force state IDLE, counter 0, result 0x00000000 and operand/accumulator registers 0.
REQ-027 After reset, stall, done, busy and illegal SHALL all be 0.
REQ-028 rst mid-operation SHALL abort without a done pulse; rst overrides flush and start.

Configuration
REQ-029 Macro MDU_CONTROLLER_DIV_EN SHALL compile in the DIV state and the divider datapath.
REQ-030 With MDU_CONTROLLER_DIV_EN defined, DIVU/REMU SHALL behave per REQ-014/016/020.
REQ-031 Without MDU_CONTROLLER_DIV_EN, DIVU/REMU SHALL be treated as unsupported (illegal=1, no stall); the DIV state and divider logic SHALL be absent.

Verification
REQ-032 MUL 7 x 6, start at edge N -> stall high N..N+32, done at N+33, result=0x0000002A.
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE; MUL on the same operands -> 0x00000001.
REQ-034 DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005.
REQ-035 MUL start, flush at cycle 10 -> IDLE next cycle, no done, result unchanged; a following MUL 3 x 3 -> 9.
REQ-036 start with funct3=001 -> illegal=1 for one cycle, stall=0, busy=0; without MDU_CONTROLLER_DIV_EN, DIVU -> the same response.
REQ-037 rst asserted at cycle 20 of a DIVU -> next cycle all outputs 0 and state IDLE; start ignored while busy -> no effect on the result.

Source files
------------

// File: rtl/mdu_controller.sv
// Iterative multiply/divide unit for the EX stage: shift-add MUL/MULHU and restoring DIVU/REMU.
// Define MDU_CONTROLLER_DIV_EN to build the divider; without it DIVU/REMU are reported illegal.
module mdu_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic        busy,
  output logic        illegal
);

  localparam logic [2:0] F3Mul   = 3'b000;
  localparam logic [2:0] F3Mulhu = 3'b011;
`ifdef MDU_CONTROLLER_DIV_EN
  localparam logic [2:0] F3Divu  = 3'b101;
  localparam logic [2:0] F3Remu  = 3'b111;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;
`endif

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;

  logic        is_mul, is_div, in_iter;
  logic [32:0] mul_sum;
  logic [63:0] step_acc;

  assign is_mul = (funct3 == F3Mul) || (funct3 == F3Mulhu);
`ifdef MDU_CONTROLLER_DIV_EN
  assign is_div  = (funct3 == F3Divu) || (funct3 == F3Remu);
  assign in_iter = (state_q == StMul) || (state_q == StDiv);
`else
  assign is_div  = 1'b0;
  assign in_iter = (state_q == StMul);
`endif

  // acc = {partial product high, multiplier}; add on the LSB, then shift right.
  assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);

`ifdef MDU_CONTROLLER_DIV_EN
  // acc = {remainder, dividend/quotient}; shift one dividend bit into the remainder per step.
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ge;

  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_diff  = div_shift[31:0] - opnd_q;
  assign div_ge    = div_shift >= {1'b0, opnd_q};

  always_comb begin
    step_acc = {mul_sum, acc_q[31:1]};
    if (state_q == StDiv) begin
      step_acc = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                        : {div_shift[31:0], acc_q[30:0], 1'b0};
    end
  end
`else
  assign step_acc = {mul_sum, acc_q[31:1]};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (start && !flush && is_mul) begin
          state_d = StMul;
          op_d    = funct3;
          opnd_d  = src_a;
          acc_d   = {32'd0, src_b};
          cnt_d   = 5'd0;
          last_d  = 1'b0;
        end else if (start && !flush && is_div) begin
`ifdef MDU_CONTROLLER_DIV_EN
          state_d = StDiv;
`endif
          op_d    = funct3;
          opnd_d  = src_b;
          acc_d   = {32'd0, src_a};
          cnt_d   = 5'd0;
          last_d  = 1'b0;
        end
      end
      StDone: state_d = StIdle;
      default: begin
        if (!in_iter || flush) begin
          state_d = StIdle;
        end else if (last_q) begin
          // Extra cycle after the 32nd step: publish the result and enter DONE.
          state_d  = StDone;
          last_d   = 1'b0;
          result_d = op_q[1] ? acc_q[63:32] : acc_q[31:0];
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            last_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      last_q   <= 1'b0;
      op_q     <= 3'd0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy    = in_iter;
  assign done    = (state_q == StDone);
  assign result  = result_q;
  assign stall   = ((state_q == StIdle) && start && (is_mul || is_div) && !flush) || in_iter;
  assign illegal = (state_q == StIdle) && start && !flush && !(is_mul || is_div);

endmodule

// File: tb/tb_mdu_controller.sv
// Directed bench for mdu_controller: scoreboard of expected results, checked when done pulses.
module tb_mdu_controller;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] src_a, src_b;
  logic        stall, done, busy, illegal;
  logic [31:0] result;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  always #5 clk = ~clk;

  mdu_controller dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .src_a   (src_a),
    .src_b   (src_b),
    .flush   (flush),
    .stall   (stall),
    .done    (done),
    .result  (result),
    .busy    (busy),
    .illegal (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (f3)
      3'b000:  return p[31:0];
      3'b011:  return p[63:32];
      3'b101:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b111:  return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Called at a negedge. Start is sampled at edge N; poke >= 0 pulses a junk start while busy.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int poke);
    logic [31:0] exp;
    start  = 1'b1;
    funct3 = f3;
    src_a  = a;
    src_b  = b;
    exp_q.push_back(model(f3, a, b));
    #1;
    chk({tag, " stall/illegal at request"}, {30'd0, stall, illegal}, 32'd2);
    @(negedge clk);
    for (int j = 0; j <= 32; j++) begin
      if (j == poke) begin
        start  = 1'b1;
        funct3 = 3'b000;
        src_a  = 32'h0000_DEAD;
        src_b  = 32'h0000_0055;
      end else begin
        start = 1'b0;
      end
      #1;
      chk({tag, " stall/busy/done while running"}, {29'd0, stall, busy, done}, 32'd6);
      @(negedge clk);
    end
    start = 1'b0;
    #1;
    chk({tag, " stall/busy/done at done"}, {29'd0, stall, busy, done}, 32'd1);
    chk({tag, " scoreboard depth"}, exp_q.size(), 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    chk({tag, " result"}, result, exp);
    last_res = exp;
    @(negedge clk);
    #1;
    chk({tag, " done one cycle"}, {29'd0, stall, busy, done}, 32'd0);
    chk({tag, " result held"}, result, last_res);
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk({tag, " no done pulse"}, seen, 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'd0;
    src_a  = 32'd0;
    src_b  = 32'd0;
    last_res = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {28'd0, stall, done, busy, illegal}, 32'd0);
    chk("reset result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("MUL 7x6", 3'b000, 32'd7, 32'd6, -1);
    chk("MUL 7x6 literal", last_res, 32'h0000_002A);
    run_op("MULHU max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("MULHU max literal", last_res, 32'hFFFF_FFFE);
    run_op("MUL max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op("MULHU 2^31x4", 3'b011, 32'h8000_0000, 32'd4, -1);
    run_op("MUL mixed", 3'b000, 32'h1234_5678, 32'h9ABC_DEF0, -1);

`ifdef MDU_CONTROLLER_DIV_EN
    run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, -1);
    chk("DIVU 100/7 literal", last_res, 32'h0000_000E);
    run_op("REMU 100/7", 3'b111, 32'd100, 32'd7, -1);
    run_op("DIVU 5/0", 3'b101, 32'd5, 32'd0, -1);
    run_op("REMU 5/0", 3'b111, 32'd5, 32'd0, -1);
    run_op("DIVU big", 3'b101, 32'hFFFF_FFF0, 32'h0001_0003, -1);
    run_op("REMU big", 3'b111, 32'hFFFF_FFF0, 32'h0001_0003, -1);
`else
    start  = 1'b1;
    funct3 = 3'b101;
    src_a  = 32'd100;
    src_b  = 32'd7;
    #1;
    chk("DIVU disabled illegal/stall", {30'd0, illegal, stall}, 32'd2);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("DIVU disabled after", {29'd0, illegal, stall, busy}, 32'd0);
    @(negedge clk);
`endif

    // Flush ten cycles into a multiply.
    start  = 1'b1;
    funct3 = 3'b000;
    src_a  = 32'h0000_1234;
    src_b  = 32'h0000_0010;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush outputs", {29'd0, stall, busy, done}, 32'd0);
    chk("flush result unchanged", result, last_res);
    expect_no_done("flush", 40);
    chk("flush result still unchanged", result, last_res);
    run_op("MUL 3x3", 3'b000, 32'd3, 32'd3, -1);

    // Unsupported funct3.
    start  = 1'b1;
    funct3 = 3'b001;
    #1;
    chk("f3=001 illegal/stall/busy", {29'd0, illegal, stall, busy}, 32'd4);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("f3=001 after", {29'd0, illegal, stall, busy}, 32'd0);

    // Flush together with start in IDLE.
    start  = 1'b1;
    funct3 = 3'b000;
    flush  = 1'b1;
    #1;
    chk("flush+start stall/illegal", {30'd0, stall, illegal}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    #1;
    chk("flush+start busy", {31'd0, busy}, 32'd0);
    expect_no_done("flush+start", 40);

    // Start pulsed while busy must not disturb the running op.
    run_op("MUL poke", 3'b000, 32'h1234_5678, 32'd9, 5);
    expect_no_done("after poke", 40);

    // Reset mid-operation overrides start and flush.
    start = 1'b1;
`ifdef MDU_CONTROLLER_DIV_EN
    funct3 = 3'b101;
`else
    funct3 = 3'b000;
`endif
    src_a = 32'd100;
    src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    #1;
    chk("mid-op reset outputs", {28'd0, stall, done, busy, illegal}, 32'd0);
    chk("mid-op reset result", result, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    expect_no_done("mid-op reset", 40);
    last_res = 32'd0;
    run_op("MUL after reset", 3'b000, 32'hCAFE_0001, 32'h0000_0100, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
